// File: rtl/bcd_time_counter.sv
// Multi-field base-60 BCD time counter (ss, mm:ss, hh:mm:ss, ...) with
// run/pause/adjust control, per-digit clamped loads and a rollover pulse.
module bcd_time_counter #(
  parameter int FIELDS = 2,
  parameter int SELW   = (2 * FIELDS > 2) ? $clog2(2 * FIELDS) : 1
) (
  input  logic                  clk_c,
  input  logic                  reset_c,
  input  logic                  tick_en,
  input  logic                  pause_btn,
  input  logic                  adj,
  input  logic                  dir,
  input  logic [SELW-1:0]       sel,
  input  logic [3:0]            num,
  input  logic                  load,
  output logic [8*FIELDS-1:0]   digits,
  output logic                  paused,
  output logic                  wrap
);

  localparam int NDIG = 2 * FIELDS;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSE  = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_pause_prev;
  logic        r_pause_armed;
  logic        w_pause_edge;
  logic        w_run;
  logic        w_adjust;
  logic        r_wrap;
  logic [3:0]  r_digit [NDIG];
  logic [NDIG:0] w_carry;

  // The button must be seen low once after reset, so a level held through
  // reset release is not mistaken for a fresh press.
  assign w_pause_edge = pause_btn & ~r_pause_prev & r_pause_armed;

  always_ff @(posedge clk_c or posedge reset_c) begin
    if (reset_c) begin
      r_state       <= ST_RUN;
      r_pause_prev  <= 1'b0;
      r_pause_armed <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pause_prev <= pause_btn;
      if (!pause_btn) begin
        r_pause_armed <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (adj) begin
      w_state_next = ST_ADJUST;
    end else if (r_state == ST_ADJUST) begin
      w_state_next = ST_PAUSE;
    end else if (w_pause_edge) begin
      w_state_next = (r_state == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
  end

  always_comb begin
    w_run    = (r_state == ST_RUN);
    w_adjust = (r_state == ST_ADJUST);
    paused   = (r_state == ST_PAUSE);
  end

  // w_carry[k] means digit k must step this cycle (carry when up, borrow when down).
  assign w_carry[0] = w_run & tick_en;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      localparam logic [3:0] DMAX = (gi % 2 == 0) ? 4'd9 : 4'd5;

      logic       w_at_max;
      logic       w_at_zero;
      logic       w_hit;
      logic [3:0] w_stepped;
      logic [3:0] w_clamped;

      assign w_at_max     = (r_digit[gi] == DMAX);
      assign w_at_zero    = (r_digit[gi] == 4'd0);
      assign w_carry[gi+1] = w_carry[gi] & (dir ? w_at_zero : w_at_max);
      assign w_stepped    = dir ? (w_at_zero ? DMAX : r_digit[gi] - 4'd1)
                                : (w_at_max ? 4'd0 : r_digit[gi] + 4'd1);
      assign w_clamped    = (num > DMAX) ? DMAX : num;
      assign w_hit        = w_adjust & load & (sel == SELW'(gi));

      always_ff @(posedge clk_c or posedge reset_c) begin
        if (reset_c) begin
          r_digit[gi] <= 4'd0;
        end else if (w_hit) begin
          r_digit[gi] <= w_clamped;
        end else if (w_carry[gi]) begin
          r_digit[gi] <= w_stepped;
        end
      end

      assign digits[4*gi +: 4] = r_digit[gi];
    end
  endgenerate

  always_ff @(posedge clk_c or posedge reset_c) begin
    if (reset_c) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_carry[NDIG];
    end
  end

  assign wrap = r_wrap;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: a 2-field and a 3-field instance share one
// stimulus stream and are checked every cycle against an arithmetic model.
module tb_bcd_time_counter;

  logic        clk_c = 1'b0;
  logic        reset_c;
  logic        tick_en;
  logic        pause_btn;
  logic        adj;
  logic        dir;
  logic        load;
  logic [2:0]  sel;
  logic [3:0]  num;
  logic [15:0] digits2;
  logic [23:0] digits3;
  logic        paused2, paused3, wrap2, wrap3;

  int tests = 0;
  int fails = 0;

  // Model: the count is a plain number of seconds modulo 60^FIELDS.
  int m_val [2];
  int m_mod [2] = '{3600, 216000};
  int m_fld [2] = '{2, 3};
  bit m_wrap [2];
  int m_state;                 // 0 run, 1 pause, 2 adjust
  bit m_prev, m_armed;

  always #5 clk_c = ~clk_c;

  bcd_time_counter #(.FIELDS(2)) dut2 (
    .clk_c(clk_c), .reset_c(reset_c), .tick_en(tick_en), .pause_btn(pause_btn),
    .adj(adj), .dir(dir), .sel(sel[1:0]), .num(num), .load(load),
    .digits(digits2), .paused(paused2), .wrap(wrap2)
  );

  bcd_time_counter #(.FIELDS(3)) dut3 (
    .clk_c(clk_c), .reset_c(reset_c), .tick_en(tick_en), .pause_btn(pause_btn),
    .adj(adj), .dir(dir), .sel(sel), .num(num), .load(load),
    .digits(digits3), .paused(paused3), .wrap(wrap3)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic int pow60(input int f);
    int p = 1;
    for (int i = 0; i < f; i++) p = p * 60;
    return p;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int f);
    logic [31:0] r = '0;
    int fv;
    for (int i = 0; i < f; i++) begin
      fv = (v / pow60(i)) % 60;
      r[8*i +: 4]   = 4'(fv % 10);
      r[8*i+4 +: 4] = 4'(fv / 10);
    end
    return r;
  endfunction

  function automatic int apply_load(input int v, input int k, input int n);
    int p, fv, t, o;
    p  = pow60(k / 2);
    fv = (v / p) % 60;
    t  = fv / 10;
    o  = fv % 10;
    if (k % 2 == 0) o = (n > 9) ? 9 : n;
    else            t = (n > 5) ? 5 : n;
    return v - fv * p + (t * 10 + o) * p;
  endfunction

  task automatic model_reset();
    m_val[0] = 0; m_val[1] = 0;
    m_wrap[0] = 0; m_wrap[1] = 0;
    m_state = 0; m_prev = 0; m_armed = 0;
  endtask

  task automatic model_update();
    bit edge_seen;
    int k;
    if (reset_c) begin
      model_reset();
      return;
    end
    edge_seen = pause_btn && !m_prev && m_armed;
    if (!pause_btn) m_armed = 1;
    m_prev = pause_btn;
    for (int i = 0; i < 2; i++) begin
      m_wrap[i] = 0;
      if (m_state == 0 && tick_en) begin
        if (dir) begin
          m_wrap[i] = (m_val[i] == 0);
          m_val[i]  = (m_val[i] + m_mod[i] - 1) % m_mod[i];
        end else begin
          m_wrap[i] = (m_val[i] == m_mod[i] - 1);
          m_val[i]  = (m_val[i] + 1) % m_mod[i];
        end
      end else if (m_state == 2 && load) begin
        k = (i == 0) ? int'(sel[1:0]) : int'(sel);
        if (k < 2 * m_fld[i]) m_val[i] = apply_load(m_val[i], k, int'(num));
      end
    end
    if (adj)                 m_state = 2;
    else if (m_state == 2)   m_state = 1;
    else if (edge_seen)      m_state = (m_state == 0) ? 1 : 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("dig2",    digits2, to_bcd(m_val[0], 2));
    chk("dig3",    digits3, to_bcd(m_val[1], 3));
    chk("paused2", paused2, (m_state == 1));
    chk("paused3", paused3, (m_state == 1));
    chk("wrap2",   wrap2,   m_wrap[0]);
    chk("wrap3",   wrap3,   m_wrap[1]);
    $display("[TB] t=%0t tick=%0b dir=%0b adj=%0b btn=%0b load=%0b sel=%0d num=%0d -> %h %h p=%0b w=%0b/%0b",
             $time, tick_en, dir, adj, pause_btn, load, sel, num, digits2, digits3, paused2, wrap2, wrap3);
  endtask

  task automatic step();
    @(posedge clk_c);
    model_update();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset_c = 1'b1;
    #1;
    model_reset();
    step();
    step();
    chk("rst_dig2", digits2, 32'h0);
    chk("rst_paused", paused2, 1'b0);
    reset_c = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] s, input logic [3:0] n);
    load = 1'b1; sel = s; num = n;
    step();
    load = 1'b0;
  endtask

  int saved;

  initial begin
    reset_c = 1'b1; tick_en = 0; pause_btn = 0; adj = 0; dir = 0;
    load = 0; sel = 0; num = 0;
    model_reset();
    do_reset();
    step();

    // Full up-count to 59:59 then rollover
    tick_en = 1; dir = 0;
    for (int i = 0; i < 3599; i++) step();
    chk("up_5959", digits2, 32'h5959);
    chk("up_005959_f3", digits3, 32'h005959);
    step();
    chk("up_wrap_dig", digits2, 32'h0000);
    chk("up_wrap_pulse", wrap2, 1'b1);
    chk("f3_carry_hour", digits3, 32'h010000);
    tick_en = 0;
    step();
    chk("wrap_one_cycle", wrap2, 1'b0);

    // Down-count rollover from 00:00
    tick_en = 1; dir = 1;
    step();
    chk("down_wrap_dig", digits2, 32'h5959);
    chk("down_wrap_pulse", wrap2, 1'b1);
    step();
    chk("down_5958", digits2, 32'h5958);
    chk("down_nowrap", wrap2, 1'b0);
    tick_en = 0; dir = 0;

    // Pause behaviour at 00:09
    do_reset();
    tick_en = 1;
    for (int i = 0; i < 9; i++) step();
    tick_en = 0; pause_btn = 1;
    step();
    pause_btn = 0; tick_en = 1;
    for (int i = 0; i < 20; i++) step();
    chk("pause_hold_dig", digits2, 32'h0009);
    chk("pause_state", paused2, 1'b1);
    tick_en = 0; pause_btn = 1;
    for (int i = 0; i < 10; i++) step();
    chk("held_btn_once", paused2, 1'b0);
    pause_btn = 0;
    step();

    // Adjust with clamping, then resume
    adj = 1;
    step();
    do_load(3'd0, 4'd0);
    do_load(3'd1, 4'd7);
    do_load(3'd2, 4'd12);
    do_load(3'd3, 4'd4);
    chk("adj_4950", digits2, 32'h4950);
    adj = 0;
    step();
    chk("adj_exit_pause", paused2, 1'b1);
    pause_btn = 1;
    step();
    pause_btn = 0; tick_en = 1;
    for (int i = 0; i < 10; i++) step();
    chk("resume_5000", digits2, 32'h5000);
    tick_en = 0;

    // Out-of-range select on the 3-field instance
    adj = 1;
    step();
    saved = m_val[1];
    do_load(3'd6, 4'd3);
    chk("sel6_noop_f3", digits3, to_bcd(saved, 3));
    adj = 0;
    step();

    // Randomised phase
    for (int i = 0; i < 600; i++) begin
      tick_en   = 1'($urandom_range(0, 1));
      dir       = 1'($urandom_range(0, 1));
      pause_btn = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) adj = ~adj;
      load      = 1'($urandom_range(0, 1));
      sel       = 3'($urandom_range(0, 7));
      num       = 4'($urandom_range(0, 15));
      step();
    end
    load = 0; pause_btn = 0; tick_en = 0;

    // Asynchronous reset mid-cycle during an adjust load at 12:34
    adj = 1;
    step();
    do_load(3'd3, 4'd1);
    do_load(3'd2, 4'd2);
    do_load(3'd1, 4'd3);
    do_load(3'd0, 4'd4);
    chk("adj_1234", digits2, 32'h1234);
    load = 1; sel = 3'd0; num = 4'd9;
    #3;
    reset_c = 1'b1;
    #1;
    chk("async_rst_dig2", digits2, 32'h0);
    chk("async_rst_dig3", digits3, 32'h0);
    chk("async_rst_paused", paused2, 1'b0);
    chk("async_rst_wrap", wrap2, 1'b0);
    model_reset();
    load = 0; adj = 0; pause_btn = 1;
    step();
    step();
    reset_c = 1'b0;

    // Button held through release: no toggle until it falls and rises
    tick_en = 1;
    step();
    chk("first_tick_0001", digits2, 32'h0001);
    tick_en = 0;
    for (int i = 0; i < 3; i++) step();
    chk("held_through_release", paused2, 1'b0);
    pause_btn = 0;
    step();
    pause_btn = 1;
    step();
    chk("fresh_press_pauses", paused2, 1'b1);
    pause_btn = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
